// File: rtl/prefetch_fifo.sv
// Instruction prefetch FIFO between fetch and decode: DEPTH-entry circular buffer of {instr, pc}
// with valid/ready on both sides, single-cycle flush and occupancy count.
// Optional macro PREFETCH_FIFO_FULL_PASS_EN lets a full FIFO accept while its head drains.
module prefetch_fifo #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned A_WIDTH = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_instr,
    input  logic [A_WIDTH-1:0] in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_instr,
    output logic [A_WIDTH-1:0] out_pc,
    output logic [CNT_W-1:0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [D_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [D_WIDTH-1:0] instr_mem_d [DEPTH];
    logic [A_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [A_WIDTH-1:0] pc_mem_d    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full, push, pop;

    assign full = (count_q == CNT_W'(DEPTH));

`ifdef PREFETCH_FIFO_FULL_PASS_EN
    // Full with out_ready implies out_valid, so the accepted push always pairs with a pop.
    assign in_ready = !full || out_ready;
`else
    assign in_ready = !full;
`endif

    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush) begin
            // Storage is left stale; only the bookkeeping is reset.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = in_instr;
                pc_mem_d[wr_ptr_q]    = in_pc;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_prefetch_fifo.sv
// Randomized and directed bench for prefetch_fifo against a queue-based reference model.
module tb_prefetch_fifo;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] model_q[$];

    prefetch_fifo #(
        .D_WIDTH(32),
        .A_WIDTH(32),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic model_in_ready(input logic ordy);
`ifdef PREFETCH_FIFO_FULL_PASS_EN
        return (model_q.size() != DEPTH) || ordy;
`else
        return model_q.size() != DEPTH;
`endif
    endfunction

    // Drive one cycle of inputs, compare outputs against the model, then advance the model.
    task automatic cycle(input logic r, input logic fl, input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic ordy);
        logic exp_rdy, do_push, do_pop;
        rst = r; flush = fl; in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy;
        #1;
        exp_rdy = model_in_ready(ordy);
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        check("out_valid", {63'd0, out_valid}, {63'd0, model_q.size() != 0});
        check("count", {61'd0, count}, 64'(model_q.size()));
        if (model_q.size() != 0) check("head", {out_instr, out_pc}, model_q[0]);
        do_push = v && exp_rdy;
        do_pop  = (model_q.size() != 0) && ordy;
        @(posedge clk);
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({ins, pc});
        end
        @(negedge clk);
    endtask

    task automatic check_cleared();
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("rst_out_pc", {32'd0, out_pc}, 64'd0);
    endtask

    initial begin
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check_cleared();
        cycle(0, 0, 0, 0, 0, 0);

        // Three pushes then drain.
        cycle(0, 0, 1, 32'h11111111, 32'h100, 0);
        cycle(0, 0, 1, 32'h22222222, 32'h104, 0);
        cycle(0, 0, 1, 32'h33333333, 32'h108, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

        // Fill, hold a pending push while full, then drain one.
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h40 + i, 32'h300 + 4 * i, 0);
        cycle(0, 0, 1, 32'h55555555, 32'h310, 0);
        cycle(0, 0, 1, 32'h55555555, 32'h310, 0);
        check("full_count", {61'd0, count}, 64'd4);
        cycle(0, 0, 1, 32'h55555555, 32'h310, 1);
        cycle(0, 0, 1, 32'h55555555, 32'h310, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("full_count_after", {61'd0, count}, 64'd4);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1);

        // Streaming push+pop; pointers wrap twice.
        cycle(0, 0, 1, 32'h9F, 32'h9F0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 32'hA0 + i, 32'hA00 + i, 1);
        check("stream_count", {61'd0, count}, 64'd1);
        cycle(0, 0, 0, 0, 0, 1);

        // Flush with simultaneous push and pop.
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h70 + i, 32'h700 + i, 0);
        cycle(0, 1, 1, 32'h77777777, 32'h777, 1);
        check("flush_count", {61'd0, count}, 64'd0);
        cycle(0, 0, 1, 32'hDEADBEEF, 32'h200, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("flush_head", {out_instr, out_pc}, {32'hDEADBEEF, 32'h200});
        cycle(0, 0, 0, 0, 0, 1);

        // Reset while pushing with two entries held.
        cycle(0, 0, 1, 32'h81, 32'h810, 0);
        cycle(0, 0, 1, 32'h82, 32'h820, 0);
        cycle(1, 0, 1, 32'h83, 32'h830, 1);
        check_cleared();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(99) == 0), ($urandom_range(29) == 0),
                  ($urandom_range(9) < 7), $urandom, $urandom, ($urandom_range(9) < 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
